// File: rtl/chip8_pkg.sv
// Shared definitions for the Chip-8 CPU core: call-stack opcodes, the default
// stack depth and an address-width helper.
package chip8_pkg;

  typedef enum logic [1:0] {
    NOP   = 2'd0,
    PUSH  = 2'd1,
    POP   = 2'd2,
    CLEAR = 2'd3
  } stk_op_t;

  localparam int STACK_DEPTH = 16;

  // Index width for a storage array of 'depth' entries.
  // The result is never narrower than one bit.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/chip8_stack_mem.sv
// Register-array storage for the call stack. It has one synchronous write port
// and two combinational read ports. The reads return 0 for an address that is
// past the last entry, so depths that are not powers of two read cleanly.
module chip8_stack_mem
  import chip8_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = STACK_DEPTH,
  parameter int AW     = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [AW-1:0]     i_rd0_addr,
  output logic [DATA_W-1:0] o_rd0_data,
  input  logic [AW-1:0]     i_rd1_addr,
  output logic [DATA_W-1:0] o_rd1_data
);

  logic [DATA_W-1:0] w_entry [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [DATA_W-1:0] r_data;

      // Entry captures write data only when it is the addressed slot; never reset.
      always_ff @(posedge clk) begin
        if (i_wr_en && (i_wr_addr == AW'(gi))) begin
          r_data <= i_wr_data;
        end
      end

      assign w_entry[gi] = r_data;
    end
  endgenerate

  // Two independent read muxes: one for the top entry and one for the entry below it.
  always_comb begin
    o_rd0_data = '0;
    o_rd1_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_rd0_addr == AW'(i)) o_rd0_data = w_entry[i];
      if (i_rd1_addr == AW'(i)) o_rd1_data = w_entry[i];
    end
  end

endmodule

// File: rtl/chip8_call_stack.sv
// Subroutine-return stack for the Chip-8 CPU. CALL pushes a return PC and RET
// pops it. The stack also supports CLEAR. It provides a registered
// top-of-stack mirror, occupancy, full/empty status and sticky
// overflow/underflow flags. One operation is accepted per cycle, with no stall.
module chip8_call_stack
  import chip8_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = STACK_DEPTH,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              cpu_clk,
  input  logic              reset,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] writedata,
  input  logic              err_clear,
  output logic [DATA_W-1:0] outdata,
  output logic              pop_valid,
  output logic [DATA_W-1:0] top,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam int              AW       = addr_w(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  stk_op_t           w_op;
  logic [CNT_W-1:0]  r_sp;
  logic [DATA_W-1:0] r_top;
  logic [DATA_W-1:0] r_outdata;
  logic              r_pop_valid;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_empty;
  logic              w_full;
  logic              w_push_ok;
  logic              w_pop_ok;
  logic              w_ovf_set;
  logic              w_udf_set;
  logic [AW-1:0]     w_wr_addr;
  logic [AW-1:0]     w_rd0_addr;
  logic [AW-1:0]     w_rd1_addr;
  logic [DATA_W-1:0] w_rd0_data;
  logic [DATA_W-1:0] w_rd1_data;

  logic [CNT_W-1:0]  w_sp_next;
  logic [DATA_W-1:0] w_top_next;
  logic [DATA_W-1:0] w_outdata_next;
  logic              w_pop_valid_next;
  logic              w_overflow_next;
  logic              w_underflow_next;

  assign w_op = stk_op_t'(op);

  // Status is decoded from the registered pointer, so it describes the state before this op.
  assign w_empty   = (r_sp == '0);
  assign w_full    = (r_sp == FULL_CNT);
  assign w_push_ok = (w_op == PUSH) && !w_full;
  assign w_pop_ok  = (w_op == POP) && !w_empty;
  assign w_ovf_set = (w_op == PUSH) && w_full;
  assign w_udf_set = (w_op == POP) && w_empty;

  // The slot at sp is the next free entry. Slots sp-1 and sp-2 are the top and the one below it.
  // The read addresses are meaningless when the stack is too shallow; those cases are gated.
  assign w_wr_addr  = AW'(r_sp);
  assign w_rd0_addr = AW'(r_sp - CNT_W'(1));
  assign w_rd1_addr = AW'(r_sp - CNT_W'(2));

  chip8_stack_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk        (cpu_clk),
    .i_wr_en    (w_push_ok),
    .i_wr_addr  (w_wr_addr),
    .i_wr_data  (writedata),
    .i_rd0_addr (w_rd0_addr),
    .o_rd0_data (w_rd0_data),
    .i_rd1_addr (w_rd1_addr),
    .o_rd1_data (w_rd1_data)
  );

  // Next-state decode. Illegal pushes and pops leave the pointer and data untouched.
  always_comb begin
    w_sp_next        = r_sp;
    w_top_next       = r_top;
    w_outdata_next   = r_outdata;
    w_pop_valid_next = 1'b0;
    case (w_op)
      PUSH: begin
        if (w_push_ok) begin
          w_sp_next  = r_sp + CNT_W'(1);
          w_top_next = writedata;
        end
      end
      POP: begin
        if (w_pop_ok) begin
          w_sp_next        = r_sp - CNT_W'(1);
          w_outdata_next   = w_rd0_data;
          w_pop_valid_next = 1'b1;
          w_top_next       = (r_sp >= CNT_W'(2)) ? w_rd1_data : '0;
        end
      end
      CLEAR: begin
        w_sp_next  = '0;
        w_top_next = '0;
      end
      default: begin
      end
    endcase
    // A new error in the same cycle as err_clear takes priority over the clear.
    w_overflow_next  = w_ovf_set | (r_overflow  & ~err_clear);
    w_underflow_next = w_udf_set | (r_underflow & ~err_clear);
  end

  // State and output registers. Reset has priority over any op in the same cycle.
  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      r_sp        <= '0;
      r_top       <= '0;
      r_outdata   <= '0;
      r_pop_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_sp        <= w_sp_next;
      r_top       <= w_top_next;
      r_outdata   <= w_outdata_next;
      r_pop_valid <= w_pop_valid_next;
      r_overflow  <= w_overflow_next;
      r_underflow <= w_underflow_next;
    end
  end

  assign outdata   = r_outdata;
  assign pop_valid = r_pop_valid;
  assign top       = r_top;
  assign count     = r_sp;
  assign empty     = w_empty;
  assign full      = w_full;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_chip8_call_stack.sv
// Scoreboard bench for chip8_call_stack. Two instances are exercised: one at the
// default 16x16 size and one with DEPTH=5 and DATA_W=12. The driver updates a
// behavioural stack model and queues the expected post-edge state. A monitor
// compares that state after every edge, and checks popped values whenever
// pop_valid is high.
module tb_chip8_call_stack;
  import chip8_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: DEPTH=16, DATA_W=16
  logic        rst_a = 1'b1, ec_a = 1'b0;
  logic [1:0]  op_a = 2'd0;
  logic [15:0] wd_a = '0;
  logic [15:0] od_a, top_a;
  logic [4:0]  cnt_a;
  logic        pv_a, emp_a, ful_a, ovf_a, udf_a;

  // Instance B: DEPTH=5, DATA_W=12
  logic        rst_b = 1'b1, ec_b = 1'b0;
  logic [1:0]  op_b = 2'd0;
  logic [11:0] wd_b = '0;
  logic [11:0] od_b, top_b;
  logic [2:0]  cnt_b;
  logic        pv_b, emp_b, ful_b, ovf_b, udf_b;

  chip8_call_stack #(.DATA_W(16), .DEPTH(16)) dut_a (
    .cpu_clk(clk), .reset(rst_a), .op(op_a), .writedata(wd_a), .err_clear(ec_a),
    .outdata(od_a), .pop_valid(pv_a), .top(top_a), .count(cnt_a),
    .empty(emp_a), .full(ful_a), .overflow(ovf_a), .underflow(udf_a)
  );

  chip8_call_stack #(.DATA_W(12), .DEPTH(5)) dut_b (
    .cpu_clk(clk), .reset(rst_b), .op(op_b), .writedata(wd_b), .err_clear(ec_b),
    .outdata(od_b), .pop_valid(pv_b), .top(top_b), .count(cnt_b),
    .empty(emp_b), .full(ful_b), .overflow(ovf_b), .underflow(udf_b)
  );

  typedef struct packed {
    logic [15:0] outdata;
    logic        pv;
    logic [15:0] top;
    logic [4:0]  cnt;
    logic        emp;
    logic        ful;
    logic        ovf;
    logic        udf;
  } snap_t;

  typedef struct packed {
    snap_t a;
    snap_t b;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] popq_a[$];
  logic [15:0] popq_b[$];

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: a plain array used as a LIFO, with the top derived from the count.
  logic [15:0] m_mem [2][16];
  int          m_cnt [2]   = '{0, 0};
  logic [15:0] m_out [2]   = '{16'h0, 16'h0};
  logic        m_pv  [2]   = '{1'b0, 1'b0};
  logic        m_ovf [2]   = '{1'b0, 1'b0};
  logic        m_udf [2]   = '{1'b0, 1'b0};
  int          m_depth [2] = '{16, 5};
  logic [15:0] m_mask [2]  = '{16'hFFFF, 16'h0FFF};

  task automatic model_op(input int d, input logic [1:0] o, input logic [15:0] wd,
                          input logic ec, input logic rs);
    logic so, su;
    so = 1'b0;
    su = 1'b0;
    if (rs) begin
      m_cnt[d] = 0; m_out[d] = '0; m_pv[d] = 1'b0; m_ovf[d] = 1'b0; m_udf[d] = 1'b0;
    end else begin
      m_pv[d] = 1'b0;
      case (o)
        2'd1: begin
          if (m_cnt[d] == m_depth[d]) so = 1'b1;
          else begin
            m_mem[d][m_cnt[d]] = wd & m_mask[d];
            m_cnt[d] = m_cnt[d] + 1;
          end
        end
        2'd2: begin
          if (m_cnt[d] == 0) su = 1'b1;
          else begin
            m_cnt[d] = m_cnt[d] - 1;
            m_out[d] = m_mem[d][m_cnt[d]];
            m_pv[d]  = 1'b1;
            if (d == 0) popq_a.push_back(m_out[d]);
            else        popq_b.push_back(m_out[d]);
          end
        end
        2'd3: m_cnt[d] = 0;
        default: ;
      endcase
      m_ovf[d] = so | (m_ovf[d] & ~ec);
      m_udf[d] = su | (m_udf[d] & ~ec);
    end
  endtask

  function automatic snap_t mk_snap(input int d);
    snap_t s;
    s.outdata = m_out[d];
    s.pv      = m_pv[d];
    s.top     = (m_cnt[d] > 0) ? m_mem[d][m_cnt[d]-1] : 16'h0;
    s.cnt     = 5'(m_cnt[d]);
    s.emp     = (m_cnt[d] == 0);
    s.ful     = (m_cnt[d] == m_depth[d]);
    s.ovf     = m_ovf[d];
    s.udf     = m_udf[d];
    return s;
  endfunction

  // One cycle of stimulus to instance d; the other instance sees a NOP.
  task automatic step(input int d, input logic [1:0] o, input logic [15:0] wd,
                      input logic ec, input logic rs);
    exp_t e;
    @(negedge clk);
    rst_a = 1'b0; ec_a = 1'b0; op_a = 2'd0; wd_a = 16'($urandom);
    rst_b = 1'b0; ec_b = 1'b0; op_b = 2'd0; wd_b = 12'($urandom);
    if (d == 0) begin
      rst_a = rs; ec_a = ec; op_a = o; wd_a = wd;
      model_op(0, o, wd, ec, rs);
      model_op(1, 2'd0, 16'h0, 1'b0, 1'b0);
    end else begin
      rst_b = rs; ec_b = ec; op_b = o; wd_b = wd[11:0];
      model_op(0, 2'd0, 16'h0, 1'b0, 1'b0);
      model_op(1, o, wd, ec, rs);
    end
    e.a = mk_snap(0);
    e.b = mk_snap(1);
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL dut%0d %s: got %h expected %h (t=%0t)", d, nm, act, expv, $time);
    end
  endtask

  // Monitor: compare the whole visible state after each edge, and popped values on pop_valid.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("outdata",   0, 32'(od_a),  32'(e.a.outdata));
        chk("pop_valid", 0, 32'(pv_a),  32'(e.a.pv));
        chk("top",       0, 32'(top_a), 32'(e.a.top));
        chk("count",     0, 32'(cnt_a), 32'(e.a.cnt));
        chk("empty",     0, 32'(emp_a), 32'(e.a.emp));
        chk("full",      0, 32'(ful_a), 32'(e.a.ful));
        chk("overflow",  0, 32'(ovf_a), 32'(e.a.ovf));
        chk("underflow", 0, 32'(udf_a), 32'(e.a.udf));
        chk("outdata",   1, 32'(od_b),  32'(e.b.outdata));
        chk("pop_valid", 1, 32'(pv_b),  32'(e.b.pv));
        chk("top",       1, 32'(top_b), 32'(e.b.top));
        chk("count",     1, 32'(cnt_b), 32'(e.b.cnt));
        chk("empty",     1, 32'(emp_b), 32'(e.b.emp));
        chk("full",      1, 32'(ful_b), 32'(e.b.ful));
        chk("overflow",  1, 32'(ovf_b), 32'(e.b.ovf));
        chk("underflow", 1, 32'(udf_b), 32'(e.b.udf));
        $display("cycle a: cnt=%0d top=%h out=%h pv=%0d | b: cnt=%0d top=%h out=%h pv=%0d",
                 cnt_a, top_a, od_a, pv_a, cnt_b, top_b, od_b, pv_b);
      end
      if (pv_a) begin
        if (popq_a.size() == 0) chk("unexpected_pop", 0, 32'(od_a), 32'hDEAD_0000);
        else                    chk("pop_value", 0, 32'(od_a), 32'(popq_a.pop_front()));
      end
      if (pv_b) begin
        if (popq_b.size() == 0) chk("unexpected_pop", 1, 32'(od_b), 32'hDEAD_0000);
        else                    chk("pop_value", 1, 32'(od_b), 32'(popq_b.pop_front()));
      end
    end
  end

  // Driver: directed test-plan sequences, then randomized traffic.
  initial begin
    int r;
    logic [1:0] o;

    // Reset, then idle
    step(0, NOP, 16'h0, 1'b0, 1'b1);
    step(1, NOP, 16'h0, 1'b0, 1'b1);
    step(0, NOP, 16'h0, 1'b0, 1'b0);
    step(1, NOP, 16'h0, 1'b0, 1'b0);

    // Push 0x0200, 0x0204, 0x0208, then pop three times
    step(0, PUSH, 16'h0200, 1'b0, 1'b0);
    step(0, PUSH, 16'h0204, 1'b0, 1'b0);
    step(0, PUSH, 16'h0208, 1'b0, 1'b0);
    repeat (3) step(0, POP, 16'h0, 1'b0, 1'b0);

    // Fill to 16, overflow push of 0xFFFF, then pop the 16th value
    for (int i = 0; i < 16; i++) step(0, PUSH, 16'(16'h1000 + i * 4), 1'b0, 1'b0);
    step(0, PUSH, 16'hFFFF, 1'b0, 1'b0);
    step(0, POP, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) step(0, POP, 16'h0, 1'b0, 1'b0);

    // Underflow, clear, clear racing a new underflow, then clear
    step(0, POP, 16'h0, 1'b0, 1'b0);
    step(0, NOP, 16'h0, 1'b1, 1'b0);
    step(0, POP, 16'h0, 1'b1, 1'b0);
    step(0, NOP, 16'h0, 1'b1, 1'b0);

    // Five pushes, CLEAR, then push/pop 0x0300
    for (int i = 0; i < 5; i++) step(0, PUSH, 16'(16'h0A00 + i), 1'b0, 1'b0);
    step(0, CLEAR, 16'h0, 1'b0, 1'b0);
    step(0, PUSH, 16'h0300, 1'b0, 1'b0);
    step(0, POP, 16'h0, 1'b0, 1'b0);

    // Reset during alternating traffic at count=3
    step(0, PUSH, 16'h0111, 1'b0, 1'b0);
    step(0, PUSH, 16'h0222, 1'b0, 1'b0);
    step(0, POP,  16'h0, 1'b0, 1'b0);
    step(0, PUSH, 16'h0333, 1'b0, 1'b0);
    step(0, PUSH, 16'h0444, 1'b0, 1'b0);
    step(0, POP,  16'h0, 1'b0, 1'b1);
    step(0, NOP,  16'h0, 1'b0, 1'b0);

    // Small instance: full at 5th push, overflow at the 6th, then drain past empty
    for (int i = 0; i < 6; i++) step(1, PUSH, 16'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1, POP, 16'h0, 1'b0, 1'b0);
    step(1, NOP, 16'h0, 1'b1, 1'b0);

    // Randomized traffic on both instances, biased toward pushes so both reach full
    for (int i = 0; i < 700; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 45)      o = PUSH;
      else if (r < 80) o = POP;
      else if (r < 86) o = CLEAR;
      else             o = NOP;
      step(int'($urandom_range(0, 1)), o, 16'($urandom),
           ($urandom_range(0, 11) == 0), ($urandom_range(0, 79) == 0));
    end

    repeat (3) @(negedge clk);
    chk("pending_expectations", 0, 32'(exp_q.size()), 32'd0);
    chk("pending_pops", 0, 32'(popq_a.size()), 32'd0);
    chk("pending_pops", 1, 32'(popq_b.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/chip8_call_stack.md
# chip8_call_stack

Parametrised subroutine-return stack for the Chip-8 CPU core, replacing the fixed 16×16 push/pop stack. It stores return PCs on CALL (2nnn) and restores them on RET (00EE). Beyond push and pop it provides a clear operation, a registered top-of-stack view, occupancy and full/empty status, and sticky overflow and underflow error flags that the CPU control FSM uses to trap on malformed programs. It sits beside the PC register in the CPU datapath and is driven one operation per cycle by the control FSM.

## Interface
- DATA_W, default 16: width of a stored entry (PC value).
- DEPTH, default 16: number of entries; any value ≥ 2, not limited to powers of two.
- CNT_W, default $clog2(DEPTH+1): width of the occupancy count.

- cpu_clk  in  1  core clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- op  in  2  operation, stk_op_t: NOP=0, PUSH=1, POP=2, CLEAR=3.
- writedata  in  DATA_W  value pushed on PUSH.
- err_clear  in  1  clears both sticky error flags.
- outdata  out  DATA_W  value returned by the most recent successful POP. Held otherwise. Reset value 0.
- pop_valid  out  1  one-cycle pulse: outdata was updated this cycle. Reset value 0.
- top  out  DATA_W  registered copy of the current top entry; 0 when empty. Reset value 0.
- count  out  CNT_W  number of occupied entries. Reset value 0.
- empty  out  1  count == 0. Reset value 1.
- full  out  1  count == DEPTH. Reset value 0.
- overflow  out  1  sticky: a PUSH was attempted while full. Reset value 0.
- underflow  out  1  sticky: a POP was attempted while empty. Reset value 0.

## Operation
- Entries are stored at indices 0..DEPTH-1. Pointer sp equals count. The top entry is at sp-1.
- PUSH when not full:
  - mem[sp] <= writedata.
  - sp <= sp+1.
  - top <= writedata.
- PUSH when full:
  - Storage, sp and top are unchanged.
  - overflow <= 1.
  - The pushed value is dropped, not wrapped.
- POP when not empty:
  - outdata <= mem[sp-1].
  - pop_valid <= 1.
  - sp <= sp-1.
  - top <= mem[sp-2] if sp ≥ 2, else 0.
- POP when empty:
  - outdata, sp and top are unchanged.
  - pop_valid stays 0.
  - underflow <= 1.
- CLEAR:
  - sp <= 0 and top <= 0.
  - outdata is held.
  - Error flags are unaffected.
  - Storage contents are not scrubbed.
- NOP: no state change. pop_valid is 0.
- err_clear clears overflow and underflow. If an error is set in the same cycle as err_clear, the set wins.
- Arithmetic:
  - sp is CNT_W bits and never wraps.
  - full and empty are decoded from the registered sp, so they reflect state before the current op.
- reset:
  - All outputs go to their reset values and sp <= 0.
  - Storage is not reset.
  - reset overrides any op in the same cycle, including an op issued mid-sequence.

## Timing
- A single cycle per op, no stall, no ready signal. The CPU may issue a new op every cycle.
- Pop latency is 1 cycle: the POP is sampled at edge N, and outdata/pop_valid are valid after edge N.
- After an op at edge N, count, empty, full and top all reflect the post-op state.
- Back-to-back PUSH then POP of the same value returns that value on the POP cycle (read-after-write through registered storage).
- The error flags assert after the edge that sampled the offending op and remain set until err_clear or reset.

## Structure
- Shared package chip8_pkg holds:
  - the stk_op_t enum (2-bit);
  - a default constant STACK_DEPTH=16.
- Sub-module chip8_stack_mem: DEPTH×DATA_W register array with one synchronous write port and two combinational read ports, addressed at sp-1 and sp-2.
- The top level holds the pointer/count, flag logic, output registers and the top mirror.

## Test plan
- Reset, then idle: count=0, empty=1, full=0, top=0, outdata=0, overflow=underflow=0.
- Push 0x0200, 0x0204, 0x0208, then POP×3 -> outdata 0x0208, 0x0204, 0x0200 on consecutive cycles, pop_valid high for 3 cycles, top 0x0204→0x0200→0, empty=1 at end.
- DEPTH=16: 16 PUSHes (full=1), 17th PUSH of 0xFFFF -> overflow=1, count stays 16, top unchanged. POP -> the 16th value, not 0xFFFF.
- POP on empty -> underflow=1, pop_valid=0, outdata unchanged. err_clear -> flag 0. err_clear together with another empty POP -> underflow stays 1.
- Push 5 entries, CLEAR -> count=0, top=0, outdata held. Push 0x0300, POP -> 0x0300.
- reset asserted during alternating PUSH/POP traffic at count=3 -> next cycle all outputs are at reset values. Re-run with DEPTH=5 and DATA_W=12: the full/overflow boundary occurs at the 5th/6th push.
